inst_fetch_buffer: RTL and testbench

Decoupling queue between the IF stage and ID. It captures each fetched `{pc, inst}` pair, meaning the IF valid/pc pair together with the synchronous instruction-SRAM read data. It presents pairs to ID in order, so a fetch already in flight when ID stalls is never lost. It raises a stall request back to IF before it runs out of room. On a redirect it discards all wrong-path entries.

---
 rtl/inst_fetch_buffer.sv | 84 ++++++++
 tb/tb_inst_fetch_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// IF->ID decoupling queue of {pc, inst} pairs; a push at edge N is visible at the head right after edge N, with no bypass.
// in_valid is always accepted while room exists (a push is dropped when full without a pop); stallreq asks IF to stop early.
module inst_fetch_buffer #(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    input  logic                     out_ready,
    output logic                     stallreq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, wr_en;
    logic [63:0]   head;
    logic [CW-1:0] free_slots;

    always_comb begin
        pop     = (count_q != '0) && out_ready;
        push    = in_valid && ((count_q < CW'(DEPTH)) || pop);
        wr_en   = push && !flush;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        // Redirect wins over everything except the sticky error flag.
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (in_valid && !push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {in_pc, in_inst};
    end

    always_comb begin
        head         = mem_q[rptr_q];
        out_valid    = (count_q != '0);
        out_pc       = out_valid ? head[63:32] : 32'h0;
        out_inst     = out_valid ? head[31:0]  : 32'h0;
        free_slots   = CW'(DEPTH) - count_q;
        stallreq     = (free_slots <= CW'(AF_MARGIN));
        count        = count_q;
        overflow_err = ovf_q;
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed checks of the fetch buffer (DEPTH=4, AF_MARGIN=1) plus a queue-model stream.
module tb_inst_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic        stallreq;
    logic [2:0]  count;
    logic        overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_buffer #(.DEPTH(4), .AF_MARGIN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_ready(out_ready), .stallreq(stallreq), .count(count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        step();
        in_valid = 1'b0;
    endtask

    logic [63:0] model[$];
    logic        stall_prev;
    logic        do_pop, room;
    logic [31:0] seq_pc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_inst", out_inst, 0);
        check("rst_stall", stallreq, 0);
        check("rst_ovf", overflow_err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic push then consume
        out_ready = 1'b1;
        push(32'hbfc00000, 32'h24010001);
        check("basic_valid", out_valid, 1);
        check("basic_pc", out_pc, 32'hbfc00000);
        check("basic_inst", out_inst, 32'h24010001);
        check("basic_count1", count, 1);
        step();
        check("basic_count0", count, 0);
        check("basic_empty", out_valid, 0);

        // Fill with ID stalled
        out_ready = 1'b0;
        push(32'hbfc00000, 32'h24010001);
        push(32'hbfc00004, 32'h24010002);
        check("fill_stall_c2", stallreq, 0);
        push(32'hbfc00008, 32'h24010003);
        check("fill_stall_c3", stallreq, 1);
        check("fill_count3", count, 3);
        push(32'hbfc0000c, 32'h24010004);
        check("fill_count4", count, 4);
        check("fill_ovf_clear", overflow_err, 0);
        push(32'hbfc00010, 32'h24010005);
        check("drop_count4", count, 4);
        check("drop_ovf", overflow_err, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 32'hbfc00000 + 32'(4 * i));
            check("drain_inst", out_inst, 32'h24010001 + 32'(i));
            step();
            if (i == 0) check("drain_stall_c3", stallreq, 1);
            if (i == 1) check("drain_stall_c2", stallreq, 0);
        end
        check("drain_count0", count, 0);
        check("drain_empty", out_valid, 0);

        // Full with simultaneous push and pop; pointers wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h00001000 + 32'(4 * i), 32'h11110000 + 32'(i));
        check("full_count", count, 4);
        for (int k = 0; k < 6; k++) begin
            in_valid  = 1'b1;
            in_pc     = 32'h00001010 + 32'(4 * k);
            in_inst   = 32'h11110004 + 32'(k);
            out_ready = 1'b1;
            check("pp_pc", out_pc, 32'h00001000 + 32'(4 * k));
            check("pp_inst", out_inst, 32'h11110000 + 32'(k));
            step();
            check("pp_count", count, 4);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("pp_tail_pc", out_pc, 32'h00001018 + 32'(4 * i));
            check("pp_tail_inst", out_inst, 32'h11110006 + 32'(i));
            step();
        end
        check("pp_count0", count, 0);

        // Flush beats same-cycle push and pop
        out_ready = 1'b0;
        push(32'h00002000, 32'h0);
        push(32'h00002004, 32'h0);
        push(32'h00002008, 32'h0);
        check("fl_count3", count, 3);
        flush     = 1'b1;
        out_ready = 1'b1;
        push(32'hdead0000, 32'hdeadbeef);
        flush     = 1'b0;
        out_ready = 1'b0;
        check("fl_count", count, 0);
        check("fl_valid", out_valid, 0);
        check("fl_stall", stallreq, 0);
        check("fl_ovf_kept", overflow_err, 1);
        push(32'hbfc00100, 32'h3c1d0000);
        check("fl_next_pc", out_pc, 32'hbfc00100);
        check("fl_next_inst", out_inst, 32'h3c1d0000);
        check("fl_next_count", count, 1);

        // Async reset between edges
        push(32'h00003000, 32'h0);
        check("ar_count2", count, 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_count", count, 0);
        check("ar_pc", out_pc, 0);
        check("ar_ovf", overflow_err, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Random stream against a reference queue; IF sees stallreq one cycle late
        stall_prev = 1'b0;
        seq_pc     = 32'h00400000;
        for (int c = 0; c < 3000; c++) begin
            flush     = ($urandom_range(0, 99) < 2);
            in_valid  = !stall_prev && ($urandom_range(0, 1) == 1);
            in_pc     = seq_pc;
            in_inst   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            stall_prev = stallreq;
            do_pop = out_valid && out_ready;
            if (do_pop) begin
                if (model.size() == 0) check("rnd_spurious_pop", 1, 0);
                else check("rnd_head", {out_pc, out_inst}, model[0]);
            end
            room = (model.size() < 4) || (out_ready && model.size() != 0);
            step();
            if (flush) begin
                model.delete();
            end else begin
                if (out_ready && model.size() != 0) void'(model.pop_front());
                if (in_valid && room) model.push_back({in_pc, in_inst});
            end
            if (in_valid) seq_pc = seq_pc + 32'd4;
            check("rnd_count", count, 64'(model.size()));
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("rnd_no_ovf", overflow_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
